// File: rtl/nibble_pack_stream.sv
// nibble_pack_stream: packs a stream of 4-bit nibbles into NIBBLES-wide words.
// Valid/ready contract (both sides): a transfer happens on a rising clock edge
// where valid & ready are both 1; a producer holding valid keeps its data
// stable until that edge, and valid may be withdrawn before a transfer.
// A partial word can be closed early with a single-cycle flush; unfilled slots
// read as zero and the word is tagged with out_last.
module nibble_pack_stream #(
  parameter int NIBBLES   = 2,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [3:0]             in_data,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NIBBLES-1:0]   out_data,
  output logic                   out_last,
  output logic [3:0]             fill_cnt,
  output logic                   state
);

  localparam int W = 4 * NIBBLES;

  typedef logic [3:0]   nibble_t;
  typedef logic [W-1:0] word_t;

  // FILL: accumulating nibbles; HOLD: a finished word is presented downstream.
  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t  cur_state;
  word_t   acc;
  word_t   merged;
  nibble_t nibble;
  logic    accept;
  logic    last_slot;

  assign nibble    = nibble_t'(in_data);
  // In HOLD a nibble may only enter when the held word retires in the same cycle.
  assign in_ready  = (cur_state == FILL) ? 1'b1 : out_ready;
  assign out_valid = (cur_state == HOLD);
  assign accept    = in_valid & in_ready;
  assign last_slot = (fill_cnt == 4'(NIBBLES - 1));
  assign state     = cur_state;

  // Accumulator with the incoming nibble placed in slot fill_cnt. In HOLD the
  // accumulator is zero and fill_cnt is zero, so this yields a slot-0 word.
  always_comb begin
    merged = acc;
    for (int i = 0; i < NIBBLES; i++) begin
      if (fill_cnt == 4'(i)) begin
        if (LSB_FIRST) merged[4*i +: 4] = nibble;
        else           merged[4*(NIBBLES-1-i) +: 4] = nibble;
      end
    end
  end

  // Pack/hold state machine with registered word, last flag and fill count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state <= FILL;
      acc       <= '0;
      fill_cnt  <= '0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else begin
      case (cur_state)
        FILL: begin
          if (accept && (last_slot || flush)) begin
            // Word complete, or closed by flush including this nibble.
            out_data  <= merged;
            out_last  <= flush;
            cur_state <= HOLD;
            fill_cnt  <= '0;
            acc       <= '0;
          end else if (accept) begin
            acc      <= merged;
            fill_cnt <= fill_cnt + 4'd1;
          end else if (flush && (fill_cnt != 4'd0)) begin
            // Close the partial word; empty accumulator flushes are ignored.
            out_data  <= acc;
            out_last  <= 1'b1;
            cur_state <= HOLD;
            fill_cnt  <= '0;
            acc       <= '0;
          end
        end
        HOLD: begin
          if (out_ready) begin
            if (accept && flush) begin
              // Retire and immediately present a one-nibble partial word.
              out_data <= merged;
              out_last <= 1'b1;
            end else if (accept) begin
              // Retire and start the next word without a bubble.
              acc       <= merged;
              fill_cnt  <= 4'd1;
              cur_state <= FILL;
            end else begin
              cur_state <= FILL;
            end
          end
        end
        default: cur_state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_pack_stream.sv
// Bench for nibble_pack_stream: three instances share the input stimulus
// (a: NIBBLES=2 LSB first, b: NIBBLES=2 MSB first, c: NIBBLES=4 LSB first).
module tb_nibble_pack_stream;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] in_data;
  logic       flush;
  logic       out_ready;

  logic        a_in_ready, a_out_valid, a_out_last, a_state;
  logic [7:0]  a_out_data;
  logic [3:0]  a_fill;
  logic        b_in_ready, b_out_valid, b_out_last, b_state;
  logic [7:0]  b_out_data;
  logic [3:0]  b_fill;
  logic        c_in_ready, c_out_valid, c_out_last, c_state;
  logic [15:0] c_out_data;
  logic [3:0]  c_fill;

  int tests = 0;
  int fails = 0;

  logic [16:0] exp_q[$];

  nibble_pack_stream #(.NIBBLES(2), .LSB_FIRST(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_data(in_data), .flush(flush), .out_valid(a_out_valid),
    .out_ready(out_ready), .out_data(a_out_data), .out_last(a_out_last),
    .fill_cnt(a_fill), .state(a_state));

  nibble_pack_stream #(.NIBBLES(2), .LSB_FIRST(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_data(in_data), .flush(flush), .out_valid(b_out_valid),
    .out_ready(out_ready), .out_data(b_out_data), .out_last(b_out_last),
    .fill_cnt(b_fill), .state(b_state));

  nibble_pack_stream #(.NIBBLES(4), .LSB_FIRST(1'b1)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(c_in_ready),
    .in_data(in_data), .flush(flush), .out_valid(c_out_valid),
    .out_ready(out_ready), .out_data(c_out_data), .out_last(c_out_last),
    .fill_cnt(c_fill), .state(c_state));

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; in_data = 4'h0; flush = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Drive one cycle of inputs at the falling edge; outputs are read 1 time unit later.
  task automatic step(input logic v, input logic [3:0] d, input logic f, input logic r);
    @(negedge clk);
    in_valid = v; in_data = d; flush = f; out_ready = r;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = 4'h0; flush = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    tests++;
    if ({a_out_valid, a_out_data, a_out_last, a_fill, a_state} !== 15'h0) begin
      fails++; $display("FAIL reset_a got %h required 0", {a_out_valid, a_out_data, a_out_last, a_fill, a_state});
    end
    tests++;
    if ({c_out_valid, c_out_data, c_out_last, c_fill, c_state} !== 23'h0) begin
      fails++; $display("FAIL reset_c got %h required 0", {c_out_valid, c_out_data, c_out_last, c_fill, c_state});
    end
    tests++;
    if ({a_in_ready, b_in_ready, c_in_ready} !== 3'b111) begin
      fails++; $display("FAIL reset_in_ready got %b required 111", {a_in_ready, b_in_ready, c_in_ready});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_slot_order();
    do_reset();
    step(1'b1, 4'h5, 1'b0, 1'b1);
    step(1'b1, 4'hA, 1'b0, 1'b1);
    tests++;
    if (a_out_valid !== 1'b0) begin
      fails++; $display("FAIL early_valid got %b required 0", a_out_valid);
    end
    step(1'b0, 4'h0, 1'b0, 1'b1);
    tests++;
    if ({a_out_valid, a_out_data, a_out_last} !== {1'b1, 8'hA5, 1'b0}) begin
      fails++; $display("FAIL lsb_first got v=%b d=%h l=%b required v=1 d=a5 l=0", a_out_valid, a_out_data, a_out_last);
    end
    tests++;
    if ({b_out_valid, b_out_data, b_out_last} !== {1'b1, 8'h5A, 1'b0}) begin
      fails++; $display("FAIL msb_first got v=%b d=%h l=%b required v=1 d=5a l=0", b_out_valid, b_out_data, b_out_last);
    end
    step(1'b0, 4'h0, 1'b0, 1'b0);
    tests++;
    if ({a_out_valid, a_fill} !== 5'h0) begin
      fails++; $display("FAIL retire_a got v=%b fill=%0d required v=0 fill=0", a_out_valid, a_fill);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_w[4];
    int seen;
    exp_w = '{8'h12, 8'h34, 8'h56, 8'h78};
    seen = 0;
    do_reset();
    for (int i = 1; i <= 9; i++) begin
      step(i <= 8, 4'(i), 1'b0, 1'b1);
      tests++;
      if (b_in_ready !== 1'b1) begin
        fails++; $display("FAIL stream_ready cycle %0d got %b required 1", i, b_in_ready);
      end
      if (i >= 3 && (i % 2) == 1) begin
        tests++;
        if ({b_out_valid, b_out_data} !== {1'b1, exp_w[seen]}) begin
          fails++; $display("FAIL stream_word %0d got v=%b d=%h required v=1 d=%h", seen, b_out_valid, b_out_data, exp_w[seen]);
        end
        seen++;
      end else begin
        tests++;
        if (b_out_valid !== 1'b0) begin
          fails++; $display("FAIL stream_gap cycle %0d got v=%b required 0", i, b_out_valid);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    step(1'b1, 4'h3, 1'b0, 1'b0);
    step(1'b1, 4'hC, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 4'h9, 1'b0, 1'b0);
      tests++;
      if ({a_out_valid, a_out_data, a_in_ready} !== {1'b1, 8'hC3, 1'b0}) begin
        fails++; $display("FAIL bp_hold %0d got v=%b d=%h rdy=%b required v=1 d=c3 rdy=0", i, a_out_valid, a_out_data, a_in_ready);
      end
    end
    step(1'b1, 4'h9, 1'b0, 1'b1);
    tests++;
    if ({a_in_ready, a_out_data} !== {1'b1, 8'hC3}) begin
      fails++; $display("FAIL bp_release got rdy=%b d=%h required rdy=1 d=c3", a_in_ready, a_out_data);
    end
    step(1'b1, 4'h6, 1'b0, 1'b1);
    tests++;
    if ({a_out_valid, a_fill} !== {1'b0, 4'd1}) begin
      fails++; $display("FAIL bp_slot0 got v=%b fill=%0d required v=0 fill=1", a_out_valid, a_fill);
    end
    step(1'b0, 4'h0, 1'b0, 1'b1);
    tests++;
    if ({a_out_valid, a_out_data} !== {1'b1, 8'h69}) begin
      fails++; $display("FAIL bp_next got v=%b d=%h required v=1 d=69", a_out_valid, a_out_data);
    end
  endtask

  task automatic test_flush();
    do_reset();
    step(1'b1, 4'h7, 1'b0, 1'b1);
    step(1'b1, 4'h2, 1'b0, 1'b1);
    step(1'b0, 4'h0, 1'b1, 1'b1);
    tests++;
    if (c_fill !== 4'd2) begin
      fails++; $display("FAIL flush_fill got %0d required 2", c_fill);
    end
    step(1'b1, 4'h1, 1'b0, 1'b1);
    tests++;
    if ({c_out_valid, c_out_data, c_out_last} !== {1'b1, 16'h0027, 1'b1}) begin
      fails++; $display("FAIL flush_partial got v=%b d=%h l=%b required v=1 d=0027 l=1", c_out_valid, c_out_data, c_out_last);
    end
    step(1'b1, 4'h2, 1'b0, 1'b1);
    step(1'b1, 4'h3, 1'b0, 1'b1);
    step(1'b1, 4'h4, 1'b0, 1'b1);
    step(1'b0, 4'h0, 1'b0, 1'b1);
    tests++;
    if ({c_out_valid, c_out_data, c_out_last} !== {1'b1, 16'h4321, 1'b0}) begin
      fails++; $display("FAIL flush_next got v=%b d=%h l=%b required v=1 d=4321 l=0", c_out_valid, c_out_data, c_out_last);
    end
  endtask

  task automatic test_flush_edges();
    do_reset();
    step(1'b0, 4'h0, 1'b1, 1'b1);
    step(1'b0, 4'h0, 1'b0, 1'b1);
    tests++;
    if ({c_out_valid, c_fill} !== 5'h0) begin
      fails++; $display("FAIL flush_empty got v=%b fill=%0d required v=0 fill=0", c_out_valid, c_fill);
    end
    step(1'b1, 4'h1, 1'b0, 1'b1);
    step(1'b1, 4'h2, 1'b0, 1'b1);
    step(1'b1, 4'h3, 1'b1, 1'b1);
    step(1'b0, 4'h0, 1'b0, 1'b0);
    tests++;
    if ({c_out_valid, c_out_data, c_out_last} !== {1'b1, 16'h0321, 1'b1}) begin
      fails++; $display("FAIL flush_with_3rd got v=%b d=%h l=%b required v=1 d=0321 l=1", c_out_valid, c_out_data, c_out_last);
    end
    // Flush while a word is held and retiring, together with a new nibble.
    step(1'b1, 4'h9, 1'b1, 1'b1);
    step(1'b0, 4'h0, 1'b0, 1'b0);
    tests++;
    if ({c_out_valid, c_out_data, c_out_last} !== {1'b1, 16'h0009, 1'b1}) begin
      fails++; $display("FAIL flush_in_hold got v=%b d=%h l=%b required v=1 d=0009 l=1", c_out_valid, c_out_data, c_out_last);
    end
    // Flush while held without a new nibble is ignored.
    step(1'b0, 4'h0, 1'b1, 1'b1);
    step(1'b0, 4'h0, 1'b0, 1'b1);
    tests++;
    if ({c_out_valid, c_fill} !== 5'h0) begin
      fails++; $display("FAIL flush_hold_idle got v=%b fill=%0d required v=0 fill=0", c_out_valid, c_fill);
    end
  endtask

  task automatic test_reset_mid_word();
    do_reset();
    step(1'b1, 4'hE, 1'b0, 1'b1);
    step(1'b0, 4'h0, 1'b0, 1'b1);
    tests++;
    if (a_fill !== 4'd1) begin
      fails++; $display("FAIL mid_fill got %0d required 1", a_fill);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if (a_fill !== 4'd0) begin
      fails++; $display("FAIL mid_async got fill=%0d required 0", a_fill);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 4'h9, 1'b0, 1'b1);
    step(1'b1, 4'h6, 1'b0, 1'b1);
    step(1'b0, 4'h0, 1'b0, 1'b1);
    tests++;
    if ({a_out_valid, a_out_data, a_out_last} !== {1'b1, 8'h69, 1'b0}) begin
      fails++; $display("FAIL mid_word got v=%b d=%h l=%b required v=1 d=69 l=0", a_out_valid, a_out_data, a_out_last);
    end
  endtask

  task automatic test_random();
    logic [15:0] cur;
    int cnt;
    int sent;
    int cycles;
    logic v, f, r;
    logic [3:0] d;
    logic [16:0] got;
    cur = '0; cnt = 0; sent = 0; cycles = 0;
    exp_q.delete();
    do_reset();
    while (sent < 10000 && cycles < 60000) begin
      v = ($urandom_range(0, 3) != 0);
      d = 4'($urandom_range(0, 15));
      f = ($urandom_range(0, 15) == 0);
      r = ($urandom_range(0, 3) != 0);
      step(v, d, f, r);
      cycles++;
      tests++;
      if (c_fill !== 4'(cnt)) begin
        fails++; $display("FAIL rand_fill cycle %0d got %0d required %0d", cycles, c_fill, cnt);
      end
      if (c_out_valid && r) begin
        got = {c_out_last, c_out_data};
        tests++;
        if (exp_q.size() == 0) begin
          fails++; $display("FAIL rand_extra got %h required no word", got);
        end else if (got !== exp_q[0]) begin
          fails++; $display("FAIL rand_word got %h required %h", got, exp_q[0]);
          void'(exp_q.pop_front());
        end else begin
          void'(exp_q.pop_front());
        end
      end
      if (v && c_in_ready) begin
        sent++;
        cur[4*cnt +: 4] = d;
        cnt++;
        if (cnt == 4 || f) begin
          exp_q.push_back({f, cur});
          cur = '0; cnt = 0;
        end
      end else if (f && cnt > 0) begin
        exp_q.push_back({1'b1, cur});
        cur = '0; cnt = 0;
      end
    end
    // Close any partial word, then drain.
    if (cnt > 0) begin
      step(1'b0, 4'h0, 1'b1, 1'b0);
      exp_q.push_back({1'b1, cur});
    end
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
      step(1'b0, 4'h0, 1'b0, 1'b1);
      if (c_out_valid) begin
        got = {c_out_last, c_out_data};
        tests++;
        if (got !== exp_q[0]) begin
          fails++; $display("FAIL rand_drain got %h required %h", got, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
    end
    tests++;
    if (exp_q.size() != 0 || sent < 10000) begin
      fails++; $display("FAIL rand_leftover got %0d words pending, %0d sent required 0 pending, 10000 sent", exp_q.size(), sent);
    end
  endtask

  initial begin
    test_reset();
    test_slot_order();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_flush_edges();
    test_reset_mid_word();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
